// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : writeback_stage_pkg                                    |
// | Description : Shared pipeline encodings for load type and writeback  |
// |               result select.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package writeback_stage_pkg;

  // Load width / sign codes carried down from decode
  localparam logic [2:0] c_LD_LW  = 3'b000;
  localparam logic [2:0] c_LD_LH  = 3'b001;
  localparam logic [2:0] c_LD_LHU = 3'b010;
  localparam logic [2:0] c_LD_LB  = 3'b011;
  localparam logic [2:0] c_LD_LBU = 3'b100;

  // Writeback result select codes
  localparam logic [1:0] c_WB_ALU  = 2'b00;
  localparam logic [1:0] c_WB_MEM  = 2'b01;
  localparam logic [1:0] c_WB_LINK = 2'b10;

endpackage
`default_nettype wire

// File: rtl/writeback_stage_load_extender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_extender                                          |
// | Description : Selects and sign/zero-extends the loaded byte, half or |
// |               word from an aligned memory word.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module load_extender
  import writeback_stage_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_word,
  input  logic [1:0]         i_offset,
  input  logic [2:0]         i_type,
  output logic [NB_DATA-1:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Halfword picks on offset[1] only; byte lane follows the full offset
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  assign w_byte = i_word[{i_offset, 3'b000} +: 8];

  // Extend the selected lane; unknown codes fall back to a full word
  always_comb begin
    o_data = i_word;
    case (i_type)
      c_LD_LH:  o_data = {{(NB_DATA-16){w_half[15]}}, w_half};
      c_LD_LHU: o_data = {{(NB_DATA-16){1'b0}}, w_half};
      c_LD_LB:  o_data = {{(NB_DATA-8){w_byte[7]}}, w_byte};
      c_LD_LBU: o_data = {{(NB_DATA-8){1'b0}}, w_byte};
      default:  o_data = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : writeback_stage                                        |
// | Description : MEM/WB pipeline latch, result mux, register write      |
// |               strobe, HALT retirement and retired-instruction count. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic [NB_DATA-1:0] i_pc_plus8,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic               i_reg_write,
  input  logic [1:0]         i_wb_sel,
  input  logic [2:0]         i_load_type,
  input  logic [1:0]         i_byte_offset,
  input  logic               i_halt,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic [NB_DATA-1:0] o_write_data,
  output logic               o_write_enable,
  output logic [NB_REG-1:0]  o_wb_rd,
  output logic               o_wb_reg_write,
  output logic               o_halted,
  output logic [31:0]        o_retired
);

  logic               r_valid;
  logic [NB_DATA-1:0] r_alu_result;
  logic [NB_DATA-1:0] r_mem_data;
  logic [NB_DATA-1:0] r_pc_plus8;
  logic [NB_REG-1:0]  r_rd;
  logic               r_reg_write;
  logic [1:0]         r_wb_sel;
  logic [2:0]         r_load_type;
  logic [1:0]         r_byte_offset;
  logic               r_halt;
  logic [31:0]        r_retired;
  logic               r_halt_counted;

  logic               w_halted;
  logic               w_retire;
  logic               w_write_enable;
  logic [NB_DATA-1:0] w_load_data;

  // A valid HALT sitting in the latch is what freezes the stage
  assign w_halted = r_valid & r_halt;

  // MEM/WB latch: reset, frozen on halt, flush beats stall, else capture
  always_ff @(posedge i_clk) begin
    if (i_reset || (!w_halted && i_flush)) begin
      r_valid       <= 1'b0;
      r_alu_result  <= '0;
      r_mem_data    <= '0;
      r_pc_plus8    <= '0;
      r_rd          <= '0;
      r_reg_write   <= 1'b0;
      r_wb_sel      <= '0;
      r_load_type   <= '0;
      r_byte_offset <= '0;
      r_halt        <= 1'b0;
    end else if (!w_halted && !i_stall) begin
      r_valid       <= i_valid;
      r_alu_result  <= i_alu_result;
      r_mem_data    <= i_mem_data;
      r_pc_plus8    <= i_pc_plus8;
      r_rd          <= i_rd;
      r_reg_write   <= i_reg_write;
      r_wb_sel      <= i_wb_sel;
      r_load_type   <= i_load_type;
      r_byte_offset <= i_byte_offset;
      r_halt        <= i_halt;
    end
  end

  // An instruction retires when it leaves the latch; a HALT retires once
  assign w_retire = r_valid & ~i_stall & ~(r_halt & r_halt_counted);

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_retired      <= '0;
      r_halt_counted <= 1'b0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
      if (r_halt) begin
        r_halt_counted <= 1'b1;
      end
    end
  end

  load_extender #(
    .NB_DATA (NB_DATA)
  ) u_load_extender (
    .i_word   (r_mem_data),
    .i_offset (r_byte_offset),
    .i_type   (r_load_type),
    .o_data   (w_load_data)
  );

  // Result mux; the spare select code yields zero
  always_comb begin
    o_write_data = '0;
    case (r_wb_sel)
      c_WB_ALU:  o_write_data = r_alu_result;
      c_WB_MEM:  o_write_data = w_load_data;
      c_WB_LINK: o_write_data = r_pc_plus8;
      default:   o_write_data = '0;
    endcase
  end

  // HALT and $0 never write the register bank
  assign w_write_enable = r_valid & r_reg_write & (r_rd != '0) & ~r_halt;

  assign o_write_reg    = r_rd;
  assign o_write_enable = w_write_enable;
  assign o_wb_rd        = r_rd;
  assign o_wb_reg_write = w_write_enable;
  assign o_halted       = w_halted;
  assign o_retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_writeback_stage                                     |
// | Description : Directed self-checking bench for writeback_stage with  |
// |               an expected-output scoreboard queue.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_alu_result;
  logic [31:0] i_mem_data;
  logic [31:0] i_pc_plus8;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic [1:0]  i_wb_sel;
  logic [2:0]  i_load_type;
  logic [1:0]  i_byte_offset;
  logic        i_halt;
  logic [4:0]  o_write_reg;
  logic [31:0] o_write_data;
  logic        o_write_enable;
  logic [4:0]  o_wb_rd;
  logic        o_wb_reg_write;
  logic        o_halted;
  logic [31:0] o_retired;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        wbrw;
    logic        halted;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  writeback_stage u_dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_valid        (i_valid),
    .i_stall        (i_stall),
    .i_flush        (i_flush),
    .i_alu_result   (i_alu_result),
    .i_mem_data     (i_mem_data),
    .i_pc_plus8     (i_pc_plus8),
    .i_rd           (i_rd),
    .i_reg_write    (i_reg_write),
    .i_wb_sel       (i_wb_sel),
    .i_load_type    (i_load_type),
    .i_byte_offset  (i_byte_offset),
    .i_halt         (i_halt),
    .o_write_reg    (o_write_reg),
    .o_write_data   (o_write_data),
    .o_write_enable (o_write_enable),
    .o_wb_rd        (o_wb_rd),
    .o_wb_reg_write (o_wb_reg_write),
    .o_halted       (o_halted),
    .o_retired      (o_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rd, input logic rw,
                     input logic [1:0] sel, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] pc8,
                     input logic [2:0] lt, input logic [1:0] off,
                     input logic halt);
    i_valid = v; i_rd = rd; i_reg_write = rw; i_wb_sel = sel;
    i_alu_result = alu; i_mem_data = mem; i_pc_plus8 = pc8;
    i_load_type = lt; i_byte_offset = off; i_halt = halt;
  endtask

  task automatic push(input logic we, input logic [4:0] wreg,
                      input logic [31:0] wdata, input logic halted,
                      input logic [31:0] ret);
    exp_t e;
    e.we = we; e.wreg = wreg; e.wdata = wdata; e.wbrw = we;
    e.halted = halted; e.ret = ret;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (o_write_enable === e.we) else begin
        failures++;
        $error("FAIL %s we got=%0b exp=%0b", tag, o_write_enable, e.we);
      end
      checks++;
      assert (o_write_reg === e.wreg && o_wb_rd === e.wreg) else begin
        failures++;
        $error("FAIL %s reg got=%0d/%0d exp=%0d", tag, o_write_reg, o_wb_rd, e.wreg);
      end
      checks++;
      assert (o_write_data === e.wdata) else begin
        failures++;
        $error("FAIL %s data got=%h exp=%h", tag, o_write_data, e.wdata);
      end
      checks++;
      assert (o_wb_reg_write === e.wbrw) else begin
        failures++;
        $error("FAIL %s wb_rw got=%0b exp=%0b", tag, o_wb_reg_write, e.wbrw);
      end
      checks++;
      assert (o_halted === e.halted) else begin
        failures++;
        $error("FAIL %s halted got=%0b exp=%0b", tag, o_halted, e.halted);
      end
      checks++;
      assert (o_retired === e.ret) else begin
        failures++;
        $error("FAIL %s retired got=%0d exp=%0d", tag, o_retired, e.ret);
      end
    end
  endtask

  logic [2:0]  ld_type [7];
  logic [1:0]  ld_off  [7];
  logic [31:0] ld_exp  [7];

  initial begin
    ld_type[0] = 3'b011; ld_off[0] = 2'd2; ld_exp[0] = 32'hFFFF_FFFF;
    ld_type[1] = 3'b100; ld_off[1] = 2'd3; ld_exp[1] = 32'h0000_0080;
    ld_type[2] = 3'b001; ld_off[2] = 2'd1; ld_exp[2] = 32'h0000_7F01;
    ld_type[3] = 3'b001; ld_off[3] = 2'd2; ld_exp[3] = 32'hFFFF_80FF;
    ld_type[4] = 3'b010; ld_off[4] = 2'd2; ld_exp[4] = 32'h0000_80FF;
    ld_type[5] = 3'b000; ld_off[5] = 2'd1; ld_exp[5] = 32'h80FF_7F01;
    ld_type[6] = 3'b111; ld_off[6] = 2'd3; ld_exp[6] = 32'h80FF_7F01;

    rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    drv(1'b1, 5'd9, 1'b1, 2'b00, 32'h9999, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1);
    cyc(); cyc();
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    chk("reset");
    rst = 1'b0;

    // ALU write
    drv(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    push(1'b1, 5'd5, 32'h1234, 1'b0, 32'd0);
    cyc(); chk("alu");
    drv(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'd1);
    cyc(); chk("alu_ret");

    // Loads from a fixed memory word
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, 5'(i + 1), 1'b1, 2'b01, 32'hDEAD, 32'h80FF_7F01, 32'h0,
          ld_type[i], ld_off[i], 1'b0);
      push(1'b1, 5'(i + 1), ld_exp[i], 1'b0, 32'(1 + i));
      cyc(); chk($sformatf("load%0d", i));
    end

    // Spare select code
    drv(1'b1, 5'd3, 1'b1, 2'b11, 32'h5, 32'h80FF_7F01, 32'h44, 3'b000, 2'd0, 1'b0);
    push(1'b1, 5'd3, 32'h0, 1'b0, 32'd8);
    cyc(); chk("sel11");

    // Writes to $0 suppressed
    drv(1'b1, 5'd0, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    push(1'b0, 5'd0, 32'h55, 1'b0, 32'd9);
    cyc(); chk("rd0");
    drv(1'b1, 5'd7, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    push(1'b1, 5'd7, 32'h77, 1'b0, 32'd10);
    cyc(); chk("rd7");

    // Stall three cycles with new inputs
    i_stall = 1'b1;
    drv(1'b1, 5'd9, 1'b1, 2'b00, 32'h99, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 5'd7, 32'h77, 1'b0, 32'd10);
      cyc(); chk($sformatf("stall%0d", i));
    end
    i_flush = 1'b1;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'd10);
    cyc(); chk("stall_flush");
    i_stall = 1'b0; i_flush = 1'b0;

    // JAL link write
    drv(1'b1, 5'd31, 1'b1, 2'b10, 32'hDEAD, 32'h0, 32'h40, 3'b000, 2'd0, 1'b0);
    push(1'b1, 5'd31, 32'h40, 1'b0, 32'd10);
    cyc(); chk("jal");

    // HALT retires, freezes the stage, counts once
    drv(1'b1, 5'd4, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1);
    push(1'b0, 5'd4, 32'h0, 1'b1, 32'd11);
    cyc(); chk("halt");
    drv(1'b1, 5'd6, 1'b1, 2'b00, 32'h66, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    push(1'b0, 5'd4, 32'h0, 1'b1, 32'd12);
    cyc(); chk("halt_freeze0");
    i_flush = 1'b1;
    push(1'b0, 5'd4, 32'h0, 1'b1, 32'd12);
    cyc(); chk("halt_freeze1");
    i_flush = 1'b0;

    // Reset while halted and stalled
    i_stall = 1'b1; rst = 1'b1;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    cyc(); chk("reset_halted");
    rst = 1'b0; i_stall = 1'b0;
    drv(1'b1, 5'd2, 1'b1, 2'b00, 32'h22, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    push(1'b1, 5'd2, 32'h22, 1'b0, 32'd0);
    cyc(); chk("resume");
    drv(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'd1);
    cyc(); chk("resume_ret");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout reached before end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter NB_DATA, default 32: data width of all data paths.
REQ-002 Parameter NB_REG, default 5: register-index width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: i_clk in 1, rising-edge clock; i_reset in 1, synchronous, active-high.
REQ-004 i_valid in 1: MEM stage presents a real instruction.
REQ-005 i_stall in 1: hold the MEM/WB latch contents.
REQ-006 i_flush in 1: replace the next capture with a bubble.
REQ-007 i_alu_result in NB_DATA: ALU result or store address.
REQ-008 i_mem_data in NB_DATA: aligned 32-bit word read from data memory.
REQ-009 i_pc_plus8 in NB_DATA: link address for JAL/JALR.
REQ-010 i_rd in NB_REG: destination register index.
REQ-011 i_reg_write in 1: instruction writes a register.
REQ-012 i_wb_sel in 2: result select (ALU / MEM / LINK).
REQ-013 i_load_type in 3: load width and sign code.
REQ-014 i_byte_offset in 2: address bits [1:0] of the load.
REQ-015 i_halt in 1: HALT instruction.
REQ-016 o_write_reg out NB_REG: register-bank write index.
REQ-017 o_write_data out NB_DATA: register-bank write data.
REQ-018 o_write_enable out 1: register-bank write strobe.
REQ-019 o_wb_rd out NB_REG and o_wb_reg_write out 1: forwarding-unit copies of the latched rd and effective write enable.
REQ-020 o_halted out 1: HALT has retired.
REQ-021 o_retired out 32: count of retired valid instructions.

Function
REQ-022 The MEM/WB latch SHALL capture all i_* fields on a rising edge when not halted, not stalled and not flushing.
REQ-023 i_flush SHALL clear the latched valid bit; when i_flush and i_stall are both high, flush SHALL win.
REQ-024 i_stall alone SHALL hold every latched field unchanged.
REQ-025 Outputs SHALL be combinational from latched fields, giving 1-cycle latency; the register bank writes on the following falling edge.
REQ-026 Result mux: ALU selects i_alu_result, MEM selects the extended load data, LINK selects i_pc_plus8; the unused code 2'b11 SHALL produce 0.
REQ-027 Load extension: LW passes the word unchanged.
REQ-028 LH/LHU select half [31:16] if offset[1]=1, else half [15:0]; LH sign-extends and LHU zero-extends; offset[0] is ignored.
REQ-029 LB/LBU select byte offset*8+:8; LB sign-extends and LBU zero-extends.
REQ-030 Unused load codes SHALL behave as LW.
REQ-031 o_write_enable SHALL equal valid AND reg_write AND (rd != 0); writes to $0 are suppressed.
REQ-032 A latched valid HALT SHALL set o_halted in the same cycle and produce no register write.
REQ-033 Once o_halted is set, the latch SHALL freeze and ignore stall and flush until reset.
REQ-034 o_retired SHALL increment by 1 on each rising edge where the latch holds a valid, non-halted instruction and i_stall=0, HALT counting once; it SHALL wrap modulo 2^32.

Reset
REQ-035 On i_reset at a rising edge: latched valid=0, all latched fields=0, o_halted=0, o_retired=0.
REQ-036 After reset, outputs SHALL be o_write_enable=0, o_write_reg=0, o_write_data=0 and o_wb_reg_write=0.
REQ-037 Reset SHALL override stall, flush and halt; reset mid-stall SHALL discard the held instruction.

Structure
REQ-038 Load-type codes (LW=000, LH=001, LHU=010, LB=011, LBU=100) and wb_sel codes (ALU=00, MEM=01, LINK=10) SHALL live in the shared pipeline package.
REQ-039 Load extension SHALL be one combinational sub-module, load_extender, with inputs word, offset and type and output data.

Verification
REQ-040 ALU write: rd=5, ALU sel, alu=0x1234 -> next cycle o_write_enable=1, o_write_reg=5, o_write_data=0x1234, o_retired=1 after the following edge.
REQ-041 Loads with mem=0x80FF7F01: LB off=2 -> 0xFFFFFFFF; LBU off=3 -> 0x00000080; LH off=1 -> 0x00007F01; LH off=2 -> 0xFFFF80FF; LHU off=2 -> 0x000080FF.
REQ-042 rd=0 with reg_write=1 -> o_write_enable=0 and o_wb_reg_write=0, while o_retired still increments.
REQ-043 Stall held 3 cycles with new inputs applied -> outputs unchanged and o_retired unchanged; stall+flush together -> o_write_enable=0 next cycle.
REQ-044 JAL, LINK sel, rd=31, pc_plus8=0x40 -> writes 0x40 to register 31; a following HALT -> o_halted=1, subsequent valid inputs are ignored, and o_retired stops.
REQ-045 Reset asserted while halted and stalled -> all outputs 0 next cycle, o_halted=0, and a normal capture resumes after reset drops.
